// File: rtl/levenshtein_pkg.sv
`default_nettype none
// ============================================================================
// Package  : levenshtein_pkg
// Purpose  : Shared sizes, marker characters, register map and loader states.
// Revision : 1.0 - initial release
// ============================================================================
package levenshtein_pkg;

  localparam int BITVECTOR_WIDTH = 16;
  localparam int MAX_WORD_LENGTH = 16;
  localparam int TABLE_BYTES     = 512;

  localparam logic [7:0] CHAR_WORD_END = 8'hFE;
  localparam logic [7:0] CHAR_DICT_END = 8'hFF;

  localparam logic [4:0] REG_CTRL    = 5'h00;
  localparam logic [4:0] REG_LENGTH  = 5'h01;
  localparam logic [4:0] REG_MASK_HI = 5'h02;
  localparam logic [4:0] REG_MASK_LO = 5'h03;
  localparam logic [4:0] REG_IVP_HI  = 5'h04;
  localparam logic [4:0] REG_IVP_LO  = 5'h05;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CLEAR    = 2'd1,
    ST_WRITE_HI = 2'd2,
    ST_WRITE_LO = 2'd3
  } loader_state_e;

endpackage
`default_nettype wire

// File: rtl/levenshtein_pattern_vector.sv
`default_nettype none
// ============================================================================
// Module   : levenshtein_pattern_vector
// Purpose  : Match vector of one character against the active word prefix.
// Revision : 1.0 - initial release
// ============================================================================
module levenshtein_pattern_vector
  import levenshtein_pkg::*;
(
  input  logic [MAX_WORD_LENGTH-1:0][7:0] word_i,
  input  logic [4:0]                      length_i,
  input  logic [7:0]                      char_i,
  output logic [BITVECTOR_WIDTH-1:0]      vector_o
);

  for (genvar j = 0; j < MAX_WORD_LENGTH; j++) begin : g_cmp
    assign vector_o[j] = (5'(j) < length_i) && (word_i[j] == char_i);
  end

endmodule
`default_nettype wire

// File: rtl/levenshtein_pattern_loader.sv
`default_nettype none
// ============================================================================
// Module   : levenshtein_pattern_loader
// Purpose  : Takes the search word over a Wishbone slave and writes the Myers
//            pattern-match table into shared SRAM through a Wishbone master.
// Options  : LEVENSHTEIN_LOADER_INCREMENTAL_CLEAR_EN - clear only the entries
//            written by the previous successful load.
// Revision : 1.0 - initial release
// ============================================================================
module levenshtein_pattern_loader
  import levenshtein_pkg::*;
#(
  parameter int MASTER_ADDR_WIDTH = 24,
  parameter int SLAVE_ADDR_WIDTH  = 24
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  output logic                         wbm_cyc_o,
  output logic                         wbm_stb_o,
  output logic [MASTER_ADDR_WIDTH-1:0] wbm_adr_o,
  output logic                         wbm_we_o,
  output logic [7:0]                   wbm_dat_o,
  input  logic                         wbm_ack_i,
  input  logic                         wbm_err_i,
  input  logic                         wbm_rty_i,
  input  logic [7:0]                   wbm_dat_i,
  input  logic                         wbs_cyc_i,
  input  logic                         wbs_stb_i,
  input  logic [SLAVE_ADDR_WIDTH-1:0]  wbs_adr_i,
  input  logic                         wbs_we_i,
  input  logic [7:0]                   wbs_dat_i,
  output logic                         wbs_ack_o,
  output logic                         wbs_err_o,
  output logic                         wbs_rty_o,
  output logic [7:0]                   wbs_dat_o
);

  loader_state_e                   state_q, state_d;
  logic                            busy_q, busy_d, error_q, error_d, done_q, done_d;
  logic [4:0]                      length_q, length_d;
  logic [MAX_WORD_LENGTH-1:0][7:0] word_q, word_d;
  logic                            ack_q, ack_d, cyc_q, cyc_d;
  logic [8:0]                      adr_q, adr_d;
  logic [7:0]                      dat_q, dat_d;
  logic [9:0]                      cnt_q, cnt_d;
  logic [3:0]                      idx_q, idx_d;
`ifdef LEVENSHTEIN_LOADER_INCREMENTAL_CLEAR_EN
  logic [MAX_WORD_LENGTH-1:0][7:0] prev_word_q, prev_word_d;
  logic [4:0]                      prev_len_q, prev_len_d;
  logic                            prev_valid_q, prev_valid_d;
`endif

  logic                       req, wr;
  logic [4:0]                 reg_adr;
  logic [31:0]                ivp_wide, mask_wide;
  logic                       bad_start;
  logic [8:0]                 clear_adr;
  logic                       clear_last;
  logic [7:0]                 cur_char;
  logic [BITVECTOR_WIDTH-1:0] cur_vec;
  logic                       unused_inputs;

  assign req       = wbs_cyc_i && wbs_stb_i && !ack_q;
  assign wr        = req && wbs_we_i;
  assign reg_adr   = wbs_adr_i[4:0];
  assign ivp_wide  = (32'd1 << length_q) - 32'd1;
  assign mask_wide = (32'd1 << length_q) >> 1;
  assign cur_char  = word_q[idx_q];

  assign unused_inputs = ^{wbm_dat_i, wbs_adr_i[SLAVE_ADDR_WIDTH-1:5]};

  levenshtein_pattern_vector u_vector (
    .word_i   (word_q),
    .length_i (length_q),
    .char_i   (cur_char),
    .vector_o (cur_vec)
  );

  always_comb begin
    bad_start = (length_q == 5'd0) || (length_q > 5'(MAX_WORD_LENGTH));
    for (int j = 0; j < MAX_WORD_LENGTH; j++) begin
      if ((5'(j) < length_q) &&
          ((word_q[j] == CHAR_WORD_END) || (word_q[j] == CHAR_DICT_END))) begin
        bad_start = 1'b1;
      end
    end
  end

  // Full clear walks bytes 0..511; the incremental clear revisits only the
  // hi/lo pairs of the previous word's characters.
  always_comb begin
    clear_adr  = cnt_q[8:0];
    clear_last = (cnt_q == 10'(TABLE_BYTES - 1));
`ifdef LEVENSHTEIN_LOADER_INCREMENTAL_CLEAR_EN
    if (prev_valid_q) begin
      clear_adr  = {prev_word_q[cnt_q[4:1]], cnt_q[0]};
      clear_last = (cnt_q == ({4'b0, prev_len_q, 1'b0} - 10'd1));
    end
`endif
  end

  always_comb begin
    wbs_dat_o = 8'h00;
    if (reg_adr[4]) begin
      wbs_dat_o = word_q[reg_adr[3:0]];
    end else begin
      case (reg_adr)
        REG_CTRL:    wbs_dat_o = {5'b0, done_q, error_q, busy_q};
        REG_LENGTH:  wbs_dat_o = {3'b0, length_q};
        REG_MASK_HI: wbs_dat_o = mask_wide[15:8];
        REG_MASK_LO: wbs_dat_o = mask_wide[7:0];
        REG_IVP_HI:  wbs_dat_o = ivp_wide[15:8];
        REG_IVP_LO:  wbs_dat_o = ivp_wide[7:0];
        default:     wbs_dat_o = 8'h00;
      endcase
    end
  end

  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    error_d  = error_q;
    done_d   = done_q;
    length_d = length_q;
    word_d   = word_q;
    ack_d    = req;
    cyc_d    = cyc_q;
    adr_d    = adr_q;
    dat_d    = dat_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
`ifdef LEVENSHTEIN_LOADER_INCREMENTAL_CLEAR_EN
    prev_word_d  = prev_word_q;
    prev_len_d   = prev_len_q;
    prev_valid_d = prev_valid_q;
`endif

    if (wr && !busy_q) begin
      if (reg_adr == REG_LENGTH) length_d = wbs_dat_i[4:0];
      if (reg_adr[4])            word_d[reg_adr[3:0]] = wbs_dat_i;
      if ((reg_adr == REG_CTRL) && wbs_dat_i[0]) begin
        done_d = 1'b0;
        if (bad_start) begin
          error_d = 1'b1;
`ifdef LEVENSHTEIN_LOADER_INCREMENTAL_CLEAR_EN
          prev_valid_d = 1'b0;
`endif
        end else begin
          busy_d  = 1'b1;
          error_d = 1'b0;
          state_d = ST_CLEAR;
          cnt_d   = 10'd0;
          idx_d   = 4'd0;
        end
      end
    end

    if (state_q != ST_IDLE) begin
      if (!cyc_q) begin
        cyc_d = 1'b1;
        case (state_q)
          ST_WRITE_HI: begin adr_d = {cur_char, 1'b0}; dat_d = cur_vec[15:8]; end
          ST_WRITE_LO: begin adr_d = {cur_char, 1'b1}; dat_d = cur_vec[7:0];  end
          default:     begin adr_d = clear_adr;        dat_d = 8'h00;         end
        endcase
      end else if (wbm_err_i || wbm_rty_i) begin
        cyc_d   = 1'b0;
        busy_d  = 1'b0;
        error_d = 1'b1;
        state_d = ST_IDLE;
`ifdef LEVENSHTEIN_LOADER_INCREMENTAL_CLEAR_EN
        prev_valid_d = 1'b0;
`endif
      end else if (wbm_ack_i) begin
        cyc_d = 1'b0;
        case (state_q)
          ST_CLEAR: begin
            if (clear_last) state_d = ST_WRITE_HI;
            else            cnt_d   = cnt_q + 10'd1;
          end
          ST_WRITE_HI: state_d = ST_WRITE_LO;
          ST_WRITE_LO: begin
            if ({1'b0, idx_q} == (length_q - 5'd1)) begin
              state_d = ST_IDLE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
`ifdef LEVENSHTEIN_LOADER_INCREMENTAL_CLEAR_EN
              prev_word_d  = word_q;
              prev_len_d   = length_q;
              prev_valid_d = 1'b1;
`endif
            end else begin
              idx_d   = idx_q + 4'd1;
              state_d = ST_WRITE_HI;
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      busy_q   <= 1'b0;
      error_q  <= 1'b0;
      done_q   <= 1'b0;
      length_q <= 5'd0;
      word_q   <= '0;
      ack_q    <= 1'b0;
      cyc_q    <= 1'b0;
      adr_q    <= 9'd0;
      dat_q    <= 8'h00;
      cnt_q    <= 10'd0;
      idx_q    <= 4'd0;
`ifdef LEVENSHTEIN_LOADER_INCREMENTAL_CLEAR_EN
      prev_word_q  <= '0;
      prev_len_q   <= 5'd0;
      prev_valid_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      error_q  <= error_d;
      done_q   <= done_d;
      length_q <= length_d;
      word_q   <= word_d;
      ack_q    <= ack_d;
      cyc_q    <= cyc_d;
      adr_q    <= adr_d;
      dat_q    <= dat_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
`ifdef LEVENSHTEIN_LOADER_INCREMENTAL_CLEAR_EN
      prev_word_q  <= prev_word_d;
      prev_len_q   <= prev_len_d;
      prev_valid_q <= prev_valid_d;
`endif
    end
  end

  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;
  assign wbm_we_o  = cyc_q;
  assign wbm_adr_o = {{(MASTER_ADDR_WIDTH-9){1'b0}}, adr_q};
  assign wbm_dat_o = dat_q;
  assign wbs_ack_o = ack_q;
  assign wbs_err_o = 1'b0;
  assign wbs_rty_o = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_levenshtein_pattern_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_levenshtein_pattern_loader
// Purpose  : Directed self-checking bench with a transfer-list table model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_levenshtein_pattern_loader;

  localparam int MAW = 24;
  localparam int SAW = 24;

  logic           clk_i = 1'b0;
  logic           rst_i = 1'b1;
  logic           wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [MAW-1:0] wbm_adr_o;
  logic [7:0]     wbm_dat_o;
  logic           wbm_ack_i = 1'b0, wbm_err_i = 1'b0, wbm_rty_i = 1'b0;
  logic [7:0]     wbm_dat_i = 8'h00;
  logic           wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0, wbs_we_i = 1'b0;
  logic [SAW-1:0] wbs_adr_i = '0;
  logic [7:0]     wbs_dat_i = 8'h00;
  logic           wbs_ack_o, wbs_err_o, wbs_rty_o;
  logic [7:0]     wbs_dat_o;

  always #5 clk_i = ~clk_i;

  levenshtein_pattern_loader #(.MASTER_ADDR_WIDTH(MAW), .SLAVE_ADDR_WIDTH(SAW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_adr_o(wbm_adr_o),
    .wbm_we_o(wbm_we_o), .wbm_dat_o(wbm_dat_o), .wbm_ack_i(wbm_ack_i),
    .wbm_err_i(wbm_err_i), .wbm_rty_i(wbm_rty_i), .wbm_dat_i(wbm_dat_i),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_adr_i(wbs_adr_i),
    .wbs_we_i(wbs_we_i), .wbs_dat_i(wbs_dat_i), .wbs_ack_o(wbs_ack_o),
    .wbs_err_o(wbs_err_o), .wbs_rty_o(wbs_rty_o), .wbs_dat_o(wbs_dat_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Model: the ordered list of table writes a load must produce.
  typedef struct packed { logic [8:0] adr; logic [7:0] dat; } wr_t;
  wr_t        exp_q[$];
  wr_t        log_q[$];
  logic [7:0] mem [512];
  logic [7:0] m_word [16];
  int         m_len;
  logic [7:0] m_prev_word [16];
  int         m_prev_len;
  bit         m_prev_valid = 1'b0;
  int         xfer_total = 0;
  int         err_at = -1;
  bit         cyc_seen = 1'b0;

  function automatic void model_load();
    wr_t        e;
    logic [15:0] v;
    bit         full;
    full = 1'b1;
`ifdef LEVENSHTEIN_LOADER_INCREMENTAL_CLEAR_EN
    full = !m_prev_valid;
    if (!full) begin
      for (int k = 0; k < m_prev_len; k++) begin
        e.adr = {m_prev_word[k], 1'b0}; e.dat = 8'h00; exp_q.push_back(e);
        e.adr = {m_prev_word[k], 1'b1}; e.dat = 8'h00; exp_q.push_back(e);
      end
    end
`endif
    if (full) begin
      for (int a = 0; a < 512; a++) begin
        e.adr = 9'(a); e.dat = 8'h00; exp_q.push_back(e);
      end
    end
    for (int i = 0; i < m_len; i++) begin
      v = '0;
      for (int j = 0; j < m_len; j++) if (m_word[j] == m_word[i]) v[j] = 1'b1;
      e.adr = {m_word[i], 1'b0}; e.dat = v[15:8]; exp_q.push_back(e);
      e.adr = {m_word[i], 1'b1}; e.dat = v[7:0];  exp_q.push_back(e);
    end
  endfunction

  function automatic void model_commit();
    for (int k = 0; k < 16; k++) m_prev_word[k] = m_word[k];
    m_prev_len   = m_len;
    m_prev_valid = 1'b1;
  endfunction

  // Memory-side responder: one wait state on every third transfer.
  int  wait_state = 0;
  wr_t seen;
  always @(negedge clk_i) begin
    if (wbm_ack_i || wbm_err_i) begin
      wbm_ack_i = 1'b0;
      wbm_err_i = 1'b0;
      chk("wbm_cyc_drop", {31'b0, wbm_cyc_o}, 32'd0);
    end else if (wbm_cyc_o) begin
      cyc_seen = 1'b1;
      if (wait_state == 0 && (xfer_total % 3 == 1)) begin
        wait_state = 1;
      end else begin
        wait_state = 0;
        xfer_total++;
        chk("wbm_stb_we", {30'b0, wbm_stb_o, wbm_we_o}, 32'd3);
        seen.adr = wbm_adr_o[8:0];
        seen.dat = wbm_dat_o;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL wbm_unexpected: adr 0x%0h dat 0x%0h while no transfer is expected",
                   wbm_adr_o, wbm_dat_o);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("wbm_adr", wbm_adr_o, {23'b0, e.adr});
          chk("wbm_dat", {24'b0, wbm_dat_o}, {24'b0, e.dat});
        end
        mem[seen.adr] = seen.dat;
        log_q.push_back(seen);
        if (xfer_total == err_at) wbm_err_i = 1'b1;
        else                      wbm_ack_i = 1'b1;
      end
    end
  end

  task automatic wbs_access(input logic we, input logic [4:0] a, input logic [7:0] wd,
                            output logic [7:0] rd);
    int n;
    @(negedge clk_i);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = '0; wbs_adr_i[4:0] = a; wbs_dat_i = wd;
    n = 0;
    do begin @(negedge clk_i); n++; end while (!wbs_ack_o && n < 8);
    rd = wbs_dat_o;
    if (!wbs_ack_o) begin
      checks++; errors++;
      $display("FAIL wbs_ack_timeout: reg 0x%0h got no ack within 8 cycles, expected ack", a);
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
  endtask

  task automatic wbs_write(input logic [4:0] a, input logic [7:0] d);
    logic [7:0] dummy;
    wbs_access(1'b1, a, d, dummy);
  endtask

  task automatic rd_chk(input string name, input logic [4:0] a, input logic [7:0] exp);
    logic [7:0] d;
    wbs_access(1'b0, a, 8'h00, d);
    chk(name, {24'b0, d}, {24'b0, exp});
  endtask

  task automatic prog();
    for (int i = 0; i < m_len; i++) wbs_write(5'h10 + 5'(i), m_word[i]);
    wbs_write(5'h01, 8'(m_len));
  endtask

  task automatic wait_done(input string name);
    logic [7:0] d;
    int n;
    n = 0;
    do begin wbs_access(1'b0, 5'h00, 8'h00, d); n++; end while (d[0] && n < 2000);
    if (d[0]) begin
      checks++; errors++;
      $display("FAIL %s_timeout: busy still 1 after 2000 polls, expected 0", name);
    end
  endtask

  task automatic new_load();
    log_q.delete();
    model_load();
  endtask

  initial begin
    logic [7:0] d;
    int n82, n83, base;
    for (int k = 0; k < 16; k++) m_word[k] = 8'h00;
    repeat (3) @(negedge clk_i);
    chk("reset_outputs", {7'b0, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o},
        32'd0);
    chk("reset_wbm_dat_ack", {wbm_dat_o, wbs_ack_o, wbs_err_o, wbs_rty_o}, 32'd0);
    rst_i = 1'b0;
    rd_chk("reset_ctrl", 5'h00, 8'h00);
    @(negedge clk_i);
    chk("wbs_ack_single", {31'b0, wbs_ack_o}, 32'd0);
    rd_chk("reset_length", 5'h01, 8'h00);

    // "kitten"
    m_word[0] = 8'h6B; m_word[1] = 8'h69; m_word[2] = 8'h74;
    m_word[3] = 8'h74; m_word[4] = 8'h65; m_word[5] = 8'h6E;
    m_len = 6;
    prog();
    rd_chk("word0_readback", 5'h10, 8'h6B);
    rd_chk("length_readback", 5'h01, 8'h06);
    new_load();
    wbs_write(5'h00, 8'h01);
    wait_done("kitten");
    model_commit();
    chk("kitten_exp_left", exp_q.size(), 0);
    chk("kitten_nwrites", log_q.size(), 524);
    chk("kitten_t_hi", {24'b0, mem[9'h0E8]}, 32'h00);
    chk("kitten_t_lo", {24'b0, mem[9'h0E9]}, 32'h0C);
    chk("kitten_k_hi", {24'b0, mem[9'h0D6]}, 32'h00);
    chk("kitten_k_lo", {24'b0, mem[9'h0D7]}, 32'h01);
    chk("kitten_e_hi", {24'b0, mem[9'h0CA]}, 32'h00);
    chk("kitten_e_lo", {24'b0, mem[9'h0CB]}, 32'h10);
    rd_chk("kitten_mask_hi", 5'h02, 8'h00);
    rd_chk("kitten_mask_lo", 5'h03, 8'h20);
    rd_chk("kitten_ivp_hi", 5'h04, 8'h00);
    rd_chk("kitten_ivp_lo", 5'h05, 8'h3F);
    rd_chk("kitten_ctrl", 5'h00, 8'h04);
    rd_chk("unmapped_read", 5'h07, 8'h00);

    // Length 16, every character 'A'
    for (int k = 0; k < 16; k++) m_word[k] = 8'h41;
    m_len = 16;
    prog();
    new_load();
    wbs_write(5'h00, 8'h01);
    wait_done("len16");
    model_commit();
    chk("len16_exp_left", exp_q.size(), 0);
    n82 = 0; n83 = 0;
    foreach (log_q[k]) begin
      if (log_q[k].adr == 9'h082 && log_q[k].dat == 8'hFF) n82++;
      if (log_q[k].adr == 9'h083 && log_q[k].dat == 8'hFF) n83++;
    end
    chk("len16_hi_ff_writes", n82, 16);
    chk("len16_lo_ff_writes", n83, 16);
    rd_chk("len16_ivp_hi", 5'h04, 8'hFF);
    rd_chk("len16_ivp_lo", 5'h05, 8'hFF);
    rd_chk("len16_mask_hi", 5'h02, 8'h80);
    rd_chk("len16_mask_lo", 5'h03, 8'h00);

    // Length 0 is rejected without bus activity
    m_len = 0;
    prog();
    cyc_seen = 1'b0;
    wbs_write(5'h00, 8'h01);
    m_prev_valid = 1'b0;
    repeat (20) @(negedge clk_i);
    rd_chk("len0_ctrl", 5'h00, 8'h02);
    chk("len0_no_cyc", {31'b0, cyc_seen}, 32'd0);

    // Word-end marker inside the word is rejected
    m_word[2] = 8'hFE; m_len = 3;
    prog();
    cyc_seen = 1'b0;
    wbs_write(5'h00, 8'h01);
    m_prev_valid = 1'b0;
    repeat (20) @(negedge clk_i);
    rd_chk("marker_ctrl", 5'h00, 8'h02);
    chk("marker_no_cyc", {31'b0, cyc_seen}, 32'd0);

    // Bus error on the fifth clear write
    m_word[2] = 8'h43;
    prog();
    new_load();
    while (exp_q.size() > 5) void'(exp_q.pop_back());
    err_at = xfer_total + 5;
    wbs_write(5'h00, 8'h01);
    wait_done("err");
    m_prev_valid = 1'b0;
    cyc_seen = 1'b0;
    repeat (20) @(negedge clk_i);
    err_at = -1;
    chk("err_exp_left", exp_q.size(), 0);
    chk("err_nwrites", log_q.size(), 5);
    chk("err_no_more_cyc", {31'b0, cyc_seen}, 32'd0);
    rd_chk("err_ctrl", 5'h00, 8'h02);

    // Register writes and a second start while busy are ignored
    new_load();
    wbs_write(5'h00, 8'h01);
    repeat (10) @(negedge clk_i);
    wbs_write(5'h01, 8'h09);
    wbs_write(5'h10, 8'h55);
    wbs_write(5'h00, 8'h01);
    rd_chk("busy_ctrl", 5'h00, 8'h01);
    rd_chk("busy_length_kept", 5'h01, 8'h03);
    wait_done("busy");
    model_commit();
    chk("busy_exp_left", exp_q.size(), 0);
    chk("busy_nwrites", log_q.size(), 518);
    chk("busy_A_lo", {24'b0, mem[9'h083]}, 32'h03);
    chk("busy_C_lo", {24'b0, mem[9'h087]}, 32'h04);
    rd_chk("busy_done_ctrl", 5'h00, 8'h04);
    rd_chk("busy_word0_kept", 5'h10, 8'h41);

    // "ab" then "c"
    m_word[0] = 8'h61; m_word[1] = 8'h62; m_len = 2;
    prog();
    new_load();
    wbs_write(5'h00, 8'h01);
    wait_done("ab");
    model_commit();
    chk("ab_exp_left", exp_q.size(), 0);
    m_word[0] = 8'h63; m_len = 1;
    prog();
    new_load();
    wbs_write(5'h00, 8'h01);
    wait_done("c");
    model_commit();
    chk("c_exp_left", exp_q.size(), 0);
`ifdef LEVENSHTEIN_LOADER_INCREMENTAL_CLEAR_EN
    chk("c_nwrites", log_q.size(), 6);
    if (log_q.size() >= 4) begin
      chk("c_clear0", {23'b0, log_q[0].adr}, 32'h0C2);
      chk("c_clear1", {23'b0, log_q[1].adr}, 32'h0C3);
      chk("c_clear2", {23'b0, log_q[2].adr}, 32'h0C4);
      chk("c_clear3", {23'b0, log_q[3].adr}, 32'h0C5);
    end
`else
    chk("c_nwrites", log_q.size(), 514);
`endif
    base = log_q.size() - 2;
    if (base >= 0) begin
      chk("c_hi", {log_q[base].adr, log_q[base].dat}, {15'b0, 9'h0C6, 8'h00});
      chk("c_lo", {log_q[base+1].adr, log_q[base+1].dat}, {15'b0, 9'h0C7, 8'h01});
    end
    rd_chk("c_mask_lo", 5'h03, 8'h01);
    rd_chk("c_ivp_lo", 5'h05, 8'h01);

    // Reset in the middle of a load
    new_load();
    wbs_write(5'h00, 8'h01);
    repeat (30) @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("midreset_cyc", {31'b0, wbm_cyc_o}, 32'd0);
    rst_i = 1'b0;
    exp_q.delete();
    m_prev_valid = 1'b0;
    rd_chk("midreset_ctrl", 5'h00, 8'h00);
    rd_chk("midreset_length", 5'h01, 8'h00);
    rd_chk("midreset_word0", 5'h10, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
